data_buffer: RTL and testbench

- 64-byte circular byte FIFO shared by the USB endpoint datapath.
- The USB RX side pushes single bytes; the AHB-Lite slave reads 1–4 bytes per request.
- The AHB-Lite slave pushes 1–4 bytes per write; the USB TX side pops single bytes.
- Reports occupancy so the protocol controllers can gate transfers.

---
 rtl/data_buffer.sv | 110 +++++++++++
 tb/tb_data_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_buffer.sv
// 64-byte circular byte FIFO between the USB RX/TX byte streams and the AHB-Lite word side.
// Optional macro DATA_BUFFER_RESERVE_GUARD_EN lets buffer_reserved lock out the path that does not own the buffer.
module data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       store_rx_packet_data,
  input  logic [7:0]                 rx_packet_data,
  input  logic                       get_rx_data,
  input  logic [1:0]                 data_size,
  input  logic [31:0]                tx_data,
  input  logic                       store_tx_data,
  input  logic                       get_tx_packet_data,
  input  logic                       buffer_reserved,
  output logic [$clog2(DEPTH):0]     buffer_occupancy,
  output logic [31:0]                rx_data,
  output logic [7:0]                 tx_packet_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;

  logic          rx_gate, tx_gate;
  logic          rx_push, tx_push, rx_pop, tx_pop;
  logic [OW-1:0] room, push_req, push_cnt, pop_req, pop_cnt;
  logic [31:0]   push_word, pop_word;

`ifdef DATA_BUFFER_RESERVE_GUARD_EN
  assign rx_gate = ~buffer_reserved;
  assign tx_gate = buffer_reserved;
`else
  logic unused_reserved;
  assign unused_reserved = buffer_reserved;
  assign rx_gate = 1'b1;
  assign tx_gate = 1'b1;
`endif

  // The word-side push wins over the RX byte push; the word-side pop wins over the TX byte pop.
  assign tx_push = store_tx_data & tx_gate;
  assign rx_push = store_rx_packet_data & rx_gate & ~tx_push;
  assign rx_pop  = get_rx_data & rx_gate;
  assign tx_pop  = get_tx_packet_data & tx_gate & ~rx_pop;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    room      = OW'(DEPTH) - occ;
    push_req  = '0;
    push_word = '0;
    if (tx_push) begin
      push_req  = OW'(data_size) + OW'(1);
      push_word = tx_data;
    end else if (rx_push) begin
      push_req  = OW'(1);
      push_word = {24'h0, rx_packet_data};
    end
    push_cnt = (push_req > room) ? room : push_req;

    pop_req = '0;
    if (rx_pop)      pop_req = OW'(data_size) + OW'(1);
    else if (tx_pop) pop_req = OW'(1);
    pop_cnt = (pop_req > occ) ? occ : pop_req;

    // Bytes beyond what is stored read as zero; reads see only pre-edge contents.
    pop_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (OW'(i) < pop_cnt) pop_word[8*i +: 8] = mem[rd_ptr + AW'(i)];
    end
  end

  // NOTE: the storage array has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < 4; i++) begin
        if (OW'(i) < push_cnt) mem[wr_ptr + AW'(i)] <= push_word[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      rx_data        <= '0;
      tx_packet_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop_cnt);
      occ    <= occ + push_cnt - pop_cnt;
      if (rx_pop)      rx_data        <= pop_word;
      else if (tx_pop) tx_packet_data <= pop_word[7:0];
    end
  end

  assign buffer_occupancy = occ;

endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer: a byte-queue model predicts pops, a scoreboard queue holds expected read words.
module tb_data_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_rx_data;
  logic [1:0]  data_size;
  logic [31:0] tx_data;
  logic        store_tx_data;
  logic        get_tx_packet_data;
  logic        buffer_reserved;
  logic [6:0]  buffer_occupancy;
  logic [31:0] rx_data;
  logic [7:0]  tx_packet_data;

  data_buffer #(.DEPTH(64)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_rx_data          (get_rx_data),
    .data_size            (data_size),
    .tx_data              (tx_data),
    .store_tx_data        (store_tx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .buffer_reserved      (buffer_reserved),
    .buffer_occupancy     (buffer_occupancy),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  model_q [$];
  logic [31:0] sb_q [$];
  logic [31:0] exp_rx = '0;
  logic [7:0]  exp_tx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    clear                = 1'b0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = '0;
    get_rx_data          = 1'b0;
    data_size            = '0;
    tx_data              = '0;
    store_tx_data        = 1'b0;
    get_tx_packet_data   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".occ"}, {25'h0, buffer_occupancy}, 32'(model_q.size()));
    check({tag, ".rx"},  rx_data, exp_rx);
    check({tag, ".tx"},  {24'h0, tx_packet_data}, {24'h0, exp_tx});
  endtask

  task automatic reset_model();
    model_q.delete();
    sb_q.delete();
    exp_rx = '0;
    exp_tx = '0;
  endtask

  // One clock of requests; the model pops from pre-edge contents, then pushes into pre-edge free space.
  task automatic cycle(input string tag, input logic s_rx, input logic [7:0] rb,
                       input logic s_tx, input logic [1:0] sz, input logic [31:0] tw,
                       input logic g_rx, input logic g_tx);
    int          pre;
    int          n;
    logic [31:0] w;
    store_rx_packet_data = s_rx;
    rx_packet_data       = rb;
    store_tx_data        = s_tx;
    data_size            = sz;
    tx_data              = tw;
    get_rx_data          = g_rx;
    get_tx_packet_data   = g_tx;
    pre = model_q.size();
    w   = '0;
    if (g_rx) begin
      n = int'(sz) + 1;
      for (int i = 0; i < n; i++) if (model_q.size() > 0) w[8*i +: 8] = model_q.pop_front();
      sb_q.push_back(w);
    end else if (g_tx) begin
      if (model_q.size() > 0) w[7:0] = model_q.pop_front();
      sb_q.push_back(w);
    end
    if (s_tx) begin
      n = int'(sz) + 1;
      for (int i = 0; i < n; i++) if (i < 64 - pre) model_q.push_back(tw[8*i +: 8]);
    end else if (s_rx && pre < 64) begin
      model_q.push_back(rb);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    if (g_rx) begin
      exp_rx = sb_q.pop_front();
    end else if (g_tx) begin
      w      = sb_q.pop_front();
      exp_tx = w[7:0];
    end
    check_all(tag);
  endtask

  task automatic push_rx(input logic [7:0] b);
    cycle("push_rx", 1'b1, b, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push_tx(input logic [1:0] sz, input logic [31:0] w);
    cycle("push_tx", 1'b0, 8'h0, 1'b1, sz, w, 1'b0, 1'b0);
  endtask

  task automatic pop_rx(input logic [1:0] sz);
    cycle("pop_rx", 1'b0, 8'h0, 1'b0, sz, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic pop_tx();
    cycle("pop_tx", 1'b0, 8'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    idle_inputs();
    #1;
    reset_model();
    check_all("reset");
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst           = 1'b0;
    buffer_reserved = 1'b0;
    idle_inputs();
    #12;
    reset_model();
    check_all("por");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Four RX bytes read back as one little-endian word.
    push_rx(8'hFF); push_rx(8'hC9); push_rx(8'h9A); push_rx(8'h3B);
    check("occ4", {25'h0, buffer_occupancy}, 32'd4);
    pop_rx(2'd3);
    check("word4", rx_data, 32'h3B9AC9FF);

    // Two-byte word push drained byte-wise on the TX side.
    do_reset();
    push_tx(2'd1, 32'h00002B67);
    pop_tx();
    check("tx_lo", {24'h0, tx_packet_data}, 32'h67);
    pop_tx();
    check("tx_hi", {24'h0, tx_packet_data}, 32'h2B);

    // Fill to capacity, overflow push dropped, drain as words.
    do_reset();
    for (int i = 0; i < 64; i++) push_rx(8'(i));
    push_rx(8'hAA);
    check("full", {25'h0, buffer_occupancy}, 32'd64);
    pop_rx(2'd3);
    check("first_word", rx_data, 32'h03020100);
    for (int i = 1; i < 16; i++) pop_rx(2'd3);
    check("last_word", rx_data, 32'h3F3E3D3C);

    // Truncated word push when only two bytes fit.
    for (int i = 0; i < 62; i++) push_rx(8'(i + 100));
    push_tx(2'd3, 32'h44332211);
    check("trunc_occ", {25'h0, buffer_occupancy}, 32'd64);

    // Word push straddling index 63/0; buffer_reserved has no effect in the default build.
    do_reset();
    for (int i = 0; i < 62; i++) push_rx(8'(i));
    for (int i = 0; i < 62; i++) pop_tx();
    buffer_reserved = 1'b1;
    push_tx(2'd3, 32'hDEADBEEF);
    buffer_reserved = 1'b0;
    for (int i = 0; i < 4; i++) pop_tx();
    check("wrap_last", {24'h0, tx_packet_data}, 32'hDE);

    // Underflowing pop zero-fills the missing upper bytes.
    push_rx(8'h11); push_rx(8'h22);
    pop_rx(2'd3);
    check("underflow", rx_data, 32'h00002211);

    // Empty pops, simultaneous push/pop and the two priority rules.
    pop_tx();
    pop_rx(2'd1);
    for (int i = 0; i < 5; i++) push_rx(8'(8'h50 + 8'(i)));
    cycle("push_pop", 1'b1, 8'h77, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
    cycle("tx_over_rx", 1'b1, 8'h99, 1'b1, 2'd2, 32'h00CCBBAA, 1'b0, 1'b0);
    cycle("rx_over_tx", 1'b0, 8'h0, 1'b0, 2'd2, 32'h0, 1'b1, 1'b1);
    cycle("pop_tx_push", 1'b0, 8'h0, 1'b1, 2'd3, 32'h0D0C0B0A, 1'b0, 1'b1);

    // Clear beats a simultaneous push.
    while (model_q.size() < 10) push_rx(8'h5A);
    while (model_q.size() > 10) pop_tx();
    clear                = 1'b1;
    store_rx_packet_data = 1'b1;
    rx_packet_data       = 8'hE7;
    @(posedge clk);
    #1;
    idle_inputs();
    reset_model();
    check_all("clear");

    // Asynchronous reset while a transfer is active.
    for (int i = 0; i < 3; i++) push_rx(8'(8'hC0 + 8'(i)));
    pop_tx();
    store_rx_packet_data = 1'b1;
    rx_packet_data       = 8'h33;
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    reset_model();
    check_all("async_rst");
    idle_inputs();
    @(negedge clk);
    n_rst = 1'b1;
    push_rx(8'h42);
    pop_rx(2'd0);
    check("post_rst", rx_data, 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
